// File: rtl/fifo_read_packer.sv
// Read-side width packer: gathers RATIO consecutive FIFO words into one wide
// word with a lane valid mask, with flush of partial words and a one-deep output slot.

module fifo_read_packer_lane #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         wr,
  input  logic         keep,
  input  logic [W-1:0] d,
  output logic [W-1:0] ld
);
  logic [W-1:0] q;

  always_ff @(posedge clk or negedge rst)
    if (!rst)   q <= '0;
    else if (wr) q <= d;

  // Same-cycle write forwards straight into the slot so a completing or flushed word includes it.
  assign ld = keep ? (wr ? d : q) : '0;
endmodule

module fifo_read_packer #(
  parameter int IN_WIDTH = 8,
  parameter int RATIO    = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [IN_WIDTH-1:0]       in_data,
  input  logic                      flush,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [IN_WIDTH*RATIO-1:0] out_data,
  output logic [RATIO-1:0]          out_mask
);
  localparam int CW = $clog2(RATIO);
  localparam logic [CW-1:0] LAST = CW'(RATIO - 1);

  logic [CW-1:0] cnt, cnt_acc;
  logic          flush_pend, fp_eff;
  logic          acc, free, complete, emit_part, load;
  logic [RATIO-1:0]                wr, keep;
  logic [RATIO-1:0][IN_WIDTH-1:0]  ld_data, slot_data;
  logic [RATIO-1:0]                slot_mask;

  assign free     = ~out_valid | out_ready;
  assign in_ready = ~flush_pend & ((cnt != LAST) | free);
  assign acc      = in_valid & in_ready;
  assign complete = acc & (cnt == LAST);

  // Fill count after this cycle's accept; flush resolution looks at this value.
  always_comb begin
    cnt_acc = cnt;
    if (complete)  cnt_acc = '0;
    else if (acc)  cnt_acc = cnt + CW'(1);
  end

  assign fp_eff    = flush_pend | flush;
  assign emit_part = fp_eff & (cnt_acc != '0) & free;
  assign load      = complete | emit_part;

  genvar k;
  generate
    for (k = 0; k < RATIO; k++) begin : g_lane
      assign wr[k]   = acc & (cnt == CW'(k));
      assign keep[k] = complete | (CW'(k) < cnt_acc);
      fifo_read_packer_lane #(.W(IN_WIDTH)) u_lane (
        .clk  (clk),
        .rst  (rst),
        .wr   (wr[k]),
        .keep (keep[k]),
        .d    (in_data),
        .ld   (ld_data[k])
      );
    end
  endgenerate

  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      cnt        <= '0;
      flush_pend <= 1'b0;
    end else begin
      cnt        <= load ? '0 : cnt_acc;
      flush_pend <= fp_eff & (cnt_acc != '0) & ~free;
    end

  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      out_valid <= 1'b0;
      slot_data <= '0;
      slot_mask <= '0;
    end else if (load) begin
      out_valid <= 1'b1;
      slot_data <= ld_data;
      slot_mask <= keep;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end

  assign out_data = slot_data;
  assign out_mask = slot_mask;
endmodule

// File: tb/tb_fifo_read_packer.sv
// Directed bench for fifo_read_packer: queue-based reference model checked every
// cycle, plus literal expectations at the interesting points of each scenario.

module tb_fifo_read_packer;
  localparam int W = 8;
  localparam int R = 4;

  logic          clk = 0;
  logic          rst;
  logic          in_valid = 0, in_ready, flush = 0, out_valid, out_ready = 1;
  logic [W-1:0]  in_data = '0;
  logic [W*R-1:0] out_data;
  logic [R-1:0]  out_mask;

  int n_pass = 0, n_chk = 0;
  bit started = 0;

  fifo_read_packer #(.IN_WIDTH(W), .RATIO(R)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_mask(out_mask)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
  endtask

  // Reference model: buffered words as a queue, plus the output slot.
  logic [W-1:0]   mq[$];
  logic           m_ov = 0, m_fp = 0;
  logic [W*R-1:0] m_od = '0;
  logic [R-1:0]   m_om = '0;

  function automatic logic m_rdy();
    return !m_fp && (mq.size() < R-1 || !m_ov || out_ready);
  endfunction

  always @(posedge clk or negedge rst) begin : model
    logic fr, fp, emit;
    logic [W*R-1:0] d;
    logic [R-1:0] mk;
    if (!rst) begin
      mq.delete(); m_ov = 0; m_fp = 0; m_od = '0; m_om = '0;
    end else begin
      fr = !m_ov || out_ready;
      emit = 0; d = '0; mk = '0;
      if (in_valid && m_rdy()) mq.push_back(in_data);
      fp = m_fp || flush;
      if (mq.size() == R || (fp && mq.size() != 0 && fr)) begin
        emit = 1;
        foreach (mq[i]) d[i*W +: W] = mq[i];
        mk = R'((1 << mq.size()) - 1);
        mq.delete();
      end
      m_fp = fp && mq.size() != 0;
      if (emit) begin m_ov = 1; m_od = d; m_om = mk; end
      else if (out_ready) m_ov = 0;
    end
  end

  always @(negedge clk)
    if (started)
      chk("cycle", 64'({in_ready, out_valid, out_mask, out_data}),
                   64'({m_rdy(), m_ov, m_om, m_od}));

  task automatic drive(input logic v, input logic [W-1:0] d, input logic f, input logic r);
    in_valid = v; in_data = d; flush = f; out_ready = r;
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic feed(input logic [W-1:0] d, input logic r);
    drive(1, d, 0, r); tick();
  endtask

  task automatic chk_slot(input string name, input logic [W*R-1:0] d, input logic [R-1:0] m);
    chk({name, "_valid"}, 64'(out_valid), 64'(1));
    chk({name, "_data"},  64'(out_data),  64'(d));
    chk({name, "_mask"},  64'(out_mask),  64'(m));
    chk({name, "_model"}, 64'({m_om, m_od}), 64'({m, d}));
  endtask

  initial begin
    rst = 0;
    tick(); tick();
    started = 1;
    chk("rst_out_valid", 64'(out_valid), 64'(0));
    chk("rst_out_data",  64'(out_data),  64'(0));
    chk("rst_out_mask",  64'(out_mask),  64'(0));
    chk("rst_in_ready",  64'(in_ready),  64'(1));
    rst = 1;

    // Streaming with out_ready held high
    for (int i = 1; i <= 8; i++) begin
      feed(W'(i), 1);
      if (i == 4) chk_slot("word0", 32'h04030201, 4'hF);
      if (i == 5) chk("word0_drain", 64'(out_valid), 64'(0));
      if (i == 8) chk_slot("word1", 32'h08070605, 4'hF);
      chk("stream_ready", 64'(in_ready), 64'(1));
    end
    drive(0, 0, 0, 1); tick();

    // Partial flush of three words
    feed(8'hA1, 1); feed(8'hA2, 1); feed(8'hA3, 1);
    drive(0, 0, 1, 1); tick();
    chk_slot("flush3", 32'h00A3A2A1, 4'h7);
    chk("flush3_cnt", 64'(dut.cnt), 64'(0));

    // Flush coincident with the completing accept, then flush while empty
    feed(8'h11, 1); feed(8'h12, 1); feed(8'h13, 1);
    drive(1, 8'h14, 1, 1); tick();
    chk_slot("flush_full", 32'h14131211, 4'hF);
    drive(0, 0, 0, 1); tick();
    chk("flush_full_noextra", 64'(out_valid), 64'(0));
    drive(0, 0, 1, 1); tick();
    chk("flush_empty", 64'(out_valid), 64'(0));
    drive(0, 0, 0, 1); tick();
    chk("flush_empty2", 64'(out_valid), 64'(0));

    // Backpressure on the last lane
    for (int i = 0; i < 4; i++) feed(W'(8'h31 + i), 0);
    chk_slot("bp_full", 32'h34333231, 4'hF);
    feed(8'h21, 0); feed(8'h22, 0); feed(8'h23, 0);
    drive(1, 8'h24, 0, 0); #1;
    chk("bp_stall", 64'(in_ready), 64'(0));
    tick();
    chk_slot("bp_hold", 32'h34333231, 4'hF);
    drive(1, 8'h24, 0, 1); #1;
    chk("bp_release", 64'(in_ready), 64'(1));
    tick();
    chk_slot("bp_word", 32'h24232221, 4'hF);
    drive(0, 0, 0, 1); tick();

    // Flush while the slot is blocked
    for (int i = 0; i < 4; i++) feed(W'(8'h41 + i), 0);
    feed(8'h51, 0); feed(8'h52, 0);
    drive(0, 0, 1, 0); tick();
    drive(1, 8'h53, 0, 0); #1;
    chk("fw_ready", 64'(in_ready), 64'(0));
    chk("fw_pend",  64'(dut.flush_pend), 64'(1));
    tick();
    chk_slot("fw_hold", 32'h44434241, 4'hF);
    drive(1, 8'h53, 0, 1); #1;
    chk("fw_ready2", 64'(in_ready), 64'(0));
    tick();
    chk_slot("fw_part", 32'h00005251, 4'h3);
    for (int i = 0; i < 4; i++) feed(W'(8'h53 + i), 1);
    chk_slot("fw_next", 32'h56555453, 4'hF);
    drive(0, 0, 0, 1); tick();

    // Reset mid-fill with the slot occupied
    for (int i = 0; i < 4; i++) feed(W'(8'h61 + i), 0);
    feed(8'h71, 0); feed(8'h72, 0);
    drive(0, 0, 0, 0);
    rst = 0; #1;
    chk("mr_valid", 64'(out_valid), 64'(0));
    chk("mr_mask",  64'(out_mask),  64'(0));
    chk("mr_ready", 64'(in_ready),  64'(1));
    tick();
    rst = 1;
    for (int i = 0; i < 4; i++) feed(W'(8'h81 + i), 1);
    chk_slot("mr_next", 32'h84838281, 4'hF);
    drive(0, 0, 0, 1); tick(); tick();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/fifo_read_packer.md
# fifo_read_packer

Read-side width packer that sits directly downstream of the asynchronous FIFO core, in the read clock domain. It consumes IN_WIDTH-bit words from the FIFO read port (valid/ready) and packs RATIO consecutive words into one wide output word with a per-lane valid mask. A flush request emits a partially filled word. A single registered output slot provides backpressure to the FIFO.

## Interface
- IN_WIDTH, 8, width of each input word; must match the FIFO data width.
- RATIO, 4, number of input words per output word; must be ≥ 2.
- clk  input  1  read-domain clock; same clock as the FIFO read side.
- rst  input  1  asynchronous, active-low reset.
- in_valid  input  1  FIFO has a word; connect to FIFO valid_r.
- in_ready  output  1  packer accepts a word this cycle; connect to FIFO ready_r.
- in_data  input  IN_WIDTH  FIFO read data.
- flush  input  1  single-cycle request to emit the current partial word.
- out_valid  output  1  output slot holds a word.
- out_ready  input  1  consumer takes the word.
- out_data  output  IN_WIDTH*RATIO  packed word; lane k occupies bits [k*IN_WIDTH +: IN_WIDTH].
- out_mask  output  RATIO  bit k = 1 when lane k holds valid data.

## Operation
- State registers:
  - accumulator of RATIO lanes;
  - fill count cnt, range 0..RATIO-1, width $clog2(RATIO);
  - flush_pend flag;
  - output slot: out_valid, out_data, out_mask.
- Accept condition: acc = in_valid & in_ready. The word is written into lane cnt. Lane 0 holds the oldest word (little-endian).
- Slot free: free = ~out_valid | out_ready.
- in_ready = ~flush_pend & ((cnt != RATIO-1) | free). This term is combinational through out_ready. Lanes below the last one always accept.
- Completion occurs when acc and cnt == RATIO-1:
  - the slot loads the full word with out_mask = all ones;
  - cnt returns to 0.
- Otherwise, acc sets cnt to cnt+1.
- The flush pulse sets flush_pend. The pulse is evaluated after the same-cycle accept, so a word accepted with flush is included in the flushed word.
- flush_pend resolution, evaluated every cycle in which it is set:
  - If effective cnt == 0 (nothing buffered, or the same-cycle accept completed a full word): clear flush_pend and emit nothing.
  - Else, if free: load the slot with the filled lanes. Unfilled lanes are zero, and out_mask has the low cnt bits set. cnt returns to 0 and flush_pend clears.
  - Else: hold flush_pend. in_ready stays 0 until the slot drains.
- Flush asserted while flush_pend is already set: no additional effect.
- FSM view (derived from cnt and flush_pend, no extra state encoding):
  - EMPTY (cnt = 0): a write moves to FILL.
  - FILL (0 < cnt < RATIO): completion returns to EMPTY; flush moves to FLUSH_WAIT.
  - FLUSH_WAIT (flush_pend = 1): emit returns to EMPTY.
- Output slot:
  - When out_valid & ~out_ready, out_data and out_mask hold stable.
  - When out_ready and no new load, out_valid drops to 0 and data holds its last value.
- Reset mid-operation discards the accumulator, the pending flush and the output slot. No partial word is emitted.

## Timing
- Reset values:
  - out_valid = 0, out_data = 0, out_mask = 0;
  - cnt = 0, flush_pend = 0;
  - in_ready = 1 (combinational, as soon as rst deasserts).
- Latency: a word that completes on cycle t is visible on out_valid/out_data at cycle t+1.
- Flush latency with the slot free: the partial word is visible one cycle after the flush pulse.
- Throughput: with out_ready held at 1, in_ready stays 1 continuously. One output is produced per RATIO accepted inputs, with no bubbles.
- Backpressure: with the slot occupied and out_ready = 0, lanes 0..RATIO-2 fill and in_ready drops at cnt == RATIO-1.
  - The stall lasts until the cycle in which out_ready = 1. In that cycle the last lane is accepted and the new word replaces the drained one (back-to-back, no bubble).
- No input is dropped or duplicated. The FIFO pointer advances exactly once per acc.

## Test plan
- Reset, then 8 accepted words 0x01..0x08, out_ready = 1 → two outputs: 0x04030201 then 0x08070605, each with mask 0xF, one cycle after the 4th and 8th accept. in_ready stays 1 throughout.
- 3 words 0xA1, 0xA2, 0xA3, then a flush pulse → out_data = 0x00A3A2A1, mask 0x7 on the next cycle, and cnt = 0 afterward.
- Flush in the same cycle as the 4th accept of 0x11..0x14 → a single output 0x14131211 with mask 0xF, and no extra empty word. Flush with cnt = 0 and no accept → no output.
- out_ready = 0 with the slot full; feed 0x21..0x24 → in_ready drops after 3 accepts. Raise out_ready → the old word drains, 0x24 is accepted in the same cycle, and 0x24232221 appears on the next cycle.
- Flush with the slot full and out_ready = 0 → in_ready = 0 and flush_pend is held. Raise out_ready → the partial word appears one cycle after the drain.
- Assert rst mid-fill (cnt = 2) and with out_valid = 1 → immediately out_valid = 0, out_mask = 0 and in_ready = 1. After release, the next 4 words pack starting at lane 0.
